// File: rtl/xgs_spi_pkg.sv
// rtl/xgs_spi_pkg.sv - shared FSM state type and frame constants for the XGS SPI responder
package xgs_spi_pkg;
  typedef enum logic [1:0] {IDLE, HDR, WR_DATA, RD_DATA} state_t;
  localparam int   HDR_BITS = 16;
  localparam logic RW_READ  = 1'b1;
endpackage

// File: rtl/xgs_spi_sync.sv
// rtl/xgs_spi_sync.sv - STAGES-deep synchronizer with optional registered rise/fall pulses
module xgs_spi_sync #(
  parameter int   STAGES  = 2,
  parameter bit   EDGE_EN = 1'b1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= {STAGES{RST_VAL}};
    else        chain <= {chain[STAGES-2:0], din};
  end

  assign level = chain[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev;
      // Pulses are registered, so an edge appears STAGES+1 cycles after the pin moves.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev <= RST_VAL;
          rise <= 1'b0;
          fall <= 1'b0;
        end else begin
          prev <= level;
          rise <= level & ~prev;
          fall <= ~level & prev;
        end
      end
    end else begin : g_no_edge
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/xgs_spi_responder.sv
// rtl/xgs_spi_responder.sv - oversampled SPI slave turning XGS frames into register strobes
// XGS_SPI_RESP_BURST_EN selects auto-increment burst mode; otherwise only the first data word acts.
module xgs_spi_responder
  import xgs_spi_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_reset_n,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_sdin,
  output logic              spi_sdout,
  output logic              spi_sdout_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              frame_err
);
`ifdef XGS_SPI_RESP_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  localparam int SH_W  = (DATA_W > HDR_BITS) ? DATA_W : HDR_BITS;
  localparam int CNT_W = $clog2(SH_W);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic sdin_s, sdin_rise, sdin_fall;

  // cs_n resets to "selected" so a frame already running at reset release produces no fall edge.
  xgs_spi_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1), .RST_VAL(1'b0)) u_cs_sync (
    .clk(sys_clk), .rst_n(sys_reset_n), .din(spi_cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
  xgs_spi_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(sys_clk), .rst_n(sys_reset_n), .din(spi_sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  xgs_spi_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0), .RST_VAL(1'b0)) u_sdin_sync (
    .clk(sys_clk), .rst_n(sys_reset_n), .din(spi_sdin),
    .level(sdin_s), .rise(sdin_rise), .fall(sdin_fall));

  logic unused_sync;
  assign unused_sync = &{1'b0, cs_lvl, sclk_lvl, sdin_rise, sdin_fall};

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [SH_W-2:0]   shift_in;
  logic [SH_W-1:0]   shift_nxt;
  logic [DATA_W-1:0] shift_out;
  logic              first_word;
  logic              rd_d1;

  assign shift_nxt = {shift_in, sdin_s};

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_in     <= '0;
      shift_out    <= '0;
      first_word   <= 1'b0;
      rd_d1        <= 1'b0;
      spi_sdout    <= 1'b0;
      spi_sdout_oe <= 1'b0;
      reg_addr     <= '0;
      reg_wr       <= 1'b0;
      reg_wdata    <= '0;
      reg_rd       <= 1'b0;
      busy         <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      frame_err <= 1'b0;
      rd_d1     <= reg_rd;
      if (reg_wr && BURST) reg_addr <= reg_addr + 1'b1;

      if (cs_rise) begin
        frame_err    <= (state != IDLE) && (bit_cnt != '0);
        state        <= IDLE;
        busy         <= 1'b0;
        bit_cnt      <= '0;
        spi_sdout    <= 1'b0;
        spi_sdout_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // An SCLK edge coincident with the CS fall is dropped here by construction.
            if (cs_fall) begin
              state   <= HDR;
              busy    <= 1'b1;
              bit_cnt <= '0;
            end
          end
          HDR: begin
            if (sclk_rise) begin
              shift_in <= shift_nxt[SH_W-2:0];
              if (bit_cnt == CNT_W'(HDR_BITS - 1)) begin
                bit_cnt    <= '0;
                first_word <= 1'b1;
                reg_addr   <= shift_nxt[HDR_BITS-1 -: ADDR_W];
                if (shift_nxt[0] == RW_READ) begin
                  reg_rd       <= 1'b1;
                  spi_sdout_oe <= 1'b1;
                  state        <= RD_DATA;
                end else begin
                  state <= WR_DATA;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          WR_DATA: begin
            if (sclk_rise) begin
              shift_in <= shift_nxt[SH_W-2:0];
              if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                bit_cnt    <= '0;
                first_word <= 1'b0;
                if (BURST || first_word) begin
                  reg_wr    <= 1'b1;
                  reg_wdata <= shift_nxt[DATA_W-1:0];
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          RD_DATA: begin
            if (sclk_rise) begin
              shift_in <= shift_nxt[SH_W-2:0];
              if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                bit_cnt    <= '0;
                first_word <= 1'b0;
                if (BURST) begin
                  reg_addr <= reg_addr + 1'b1;
                  reg_rd   <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (sclk_fall) begin
              // Zeros shift in behind the word, so unrefilled words read back as 0.
              spi_sdout <= shift_out[DATA_W-1];
              shift_out <= {shift_out[DATA_W-2:0], 1'b0};
            end
          end
          default: state <= IDLE;
        endcase
      end

      if (rd_d1) shift_out <= reg_rdata;
    end
  end
endmodule

// File: doc/xgs_spi_responder.md
# xgs_spi_responder

Synthesizable SPI slave that answers the XGS sensor-programming SPI initiated by the athena controller. It decodes address/command/data frames arriving on the sensor SPI pins and turns them into single-cycle register read and write strobes on a local register-file port. It provides the validation environment's sensor-side register space, so controller sequences can program and read back registers exactly as they would on a real XGS device. It runs entirely in the system clock domain and oversamples the SPI pins.

## Interface
Parameters:
- ADDR_W, 15, register word-address width.
- DATA_W, 16, register data width and SPI data word length.
- SYNC_STAGES, 2, synchronizer depth on spi_cs_n, spi_sclk and spi_sdin; legal values are 2 and 3.

Ports:
- sys_clk  in  1  system clock; every flop in the block is on this clock.
- sys_reset_n  in  1  asynchronous active-low reset.
- spi_cs_n  in  1  chip select, active low, asynchronous to sys_clk.
- spi_sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- spi_sdin  in  1  MOSI.
- spi_sdout  out  1  MISO data.
- spi_sdout_oe  out  1  MISO output enable; high only while a read frame is in its data phase.
- reg_addr  out  ADDR_W  register word address.
- reg_wr  out  1  one-cycle write strobe.
- reg_wdata  out  DATA_W  write data, valid while reg_wr is high.
- reg_rd  out  1  one-cycle read strobe.
- reg_rdata  in  DATA_W  read data, valid exactly 1 cycle after reg_rd.
- busy  out  1  high whenever the FSM is not in IDLE.
- frame_err  out  1  one-cycle pulse when a frame aborts mid-word.

## Operation
- Frame format, MSB first:
  - Header: 16 bits, made of addr[14:0] followed by an R/W bit (1 = read).
  - Then zero or more DATA_W-bit data words.
- Bit handling:
  - MOSI is sampled on the synchronized SCLK rising edge.
  - MISO changes on the synchronized SCLK falling edge.
  - spi_sdout_oe asserts on the header's 16th rising edge for reads. The bit count then sits on a word boundary, so data MSB is driven at the first data-phase falling edge.
- FSM states:
  - IDLE: waits for a cs_n falling edge, then goes to HDR.
  - HDR: shifts in 16 bits. On the 16th bit, a read issues reg_rd with the header address and goes to RD_DATA; a write goes to WR_DATA.
  - WR_DATA: on each 16th bit, pulses reg_wr with the shifted word, then increments the address.
  - RD_DATA: loads the shift register from reg_rdata 1 cycle after reg_rd. On each 16th bit, increments the address and issues the next reg_rd (prefetch).
  - Any state goes to IDLE on a synchronized cs_n rising edge.
- Address arithmetic: the word address increments by 1 per word and wraps from 2^ADDR_W-1 to 0.
- CS rise with a nonzero bit count in HDR, WR_DATA or RD_DATA:
  - the partial word is discarded and no strobe is issued;
  - frame_err pulses.
- CS rise on a word boundary ends the frame cleanly.
- SCLK edges while cs_n is high are ignored.
- A cs_n falling edge in the same cycle as an SCLK edge: the SCLK edge is ignored.
- Reset values: spi_sdout=0, spi_sdout_oe=0, reg_addr=0, reg_wr=0, reg_wdata=0, reg_rd=0, busy=0, frame_err=0, FSM=IDLE.
- Reset mid-frame: the frame is abandoned with no strobe. After reset release the block waits for a fresh cs_n falling edge; a frame already in progress is ignored until CS rises.

## Timing
- Edge detection latency: SYNC_STAGES+1 sys_clk cycles from pin edge to internal edge pulse.
- reg_wr and reg_rd assert on the cycle the 16th rising edge is detected.
- The MISO shift register loads 2 cycles after reg_rd.
- Requirement: each SCLK half-period is at least SYNC_STAGES+4 sys_clk periods. This guarantees prefetched data is loaded before the next falling edge.
- reg_wr and reg_rd are never high together. Each is at most 1 cycle wide per word.

## Configuration
- XGS_SPI_RESP_BURST_EN defined: burst mode. Words after the first use the auto-incremented address, as described in Operation.
- Not defined: single-word mode. Only the first data word acts on the register port. Later words are shifted and ignored, with no strobes, spi_sdout=0 and spi_sdout_oe still high in reads. frame_err behaviour is unchanged.

## Structure
- Shared package xgs_spi_pkg:
  - FSM state enum (IDLE, HDR, WR_DATA, RD_DATA);
  - HDR_BITS=16;
  - RW_READ=1'b1.
- Sub-module xgs_spi_sync: SYNC_STAGES-deep synchronizer plus rise/fall edge detector, instantiated for each of cs_n, sclk and sdin (sdin without edge detect).

## Test plan
- Write 0x0ABC -> addr 0x1234 (header 0x2468): reg_wr pulses once, reg_addr=0x1234, reg_wdata=0x0ABC, frame_err=0.
- Read addr 0x0010 with reg_rdata=0x5A5A: reg_rd pulses with reg_addr=0x0010; MISO returns 0x5A5A MSB first; spi_sdout_oe falls when CS rises.
- Burst write of 3 words at 0x7FFF (BURST_EN defined): writes go to 0x7FFF, 0x0000, 0x0001. With BURST_EN undefined, only 0x7FFF is written.
- CS rise after 9 data bits of a write: no reg_wr, frame_err pulses once, busy=0 within SYNC_STAGES+2 cycles.
- Reset asserted mid-read: all outputs 0 immediately. The next full frame after CS cycles completes normally.
- SCLK toggling with cs_n high: no strobes, busy stays 0.
